multiplicador_param: RTL and testbench

- Parametrised shift-and-add sequential multiplier for the ALU datapath.
- Generalises the fixed 3-bit unsigned multiplier to WIDTH-bit operands.
- Adds a runtime signed/unsigned mode, early termination once the multiplier is exhausted, operand capture at start, a busy flag, and a one-cycle done pulse.
- Sits beside the other ALU operation units; the ALU operation selector drives init and reads resultado on done.

---
 rtl/multiplicador_param.sv | 112 +++++++++++
 tb/tb_multiplicador_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_param.sv
// Sequential shift-and-add multiplier with WIDTH-bit operands and a runtime signed/unsigned mode.
// The product is built from operand magnitudes and sign-corrected once the multiplier is exhausted.
module multiplicador_param #(
   parameter int unsigned WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     MD,
   input  logic [WIDTH-1:0]     MR,
   output logic [2*WIDTH-1:0]   resultado,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_ADD,
      S_SHIFT,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_next;
   logic [2*WIDTH-1:0]   a;
   logic [2*WIDTH-1:0]   pp;
   logic [WIDTH-1:0]     b;
   logic                 sign;
   logic [WIDTH-1:0]     md_mag;
   logic [WIDTH-1:0]     mr_mag;

   // The most negative operand negates to itself, which read unsigned is its true magnitude.
   always_comb begin
      md_mag = (signed_mode && MD[WIDTH-1]) ? (~MD + ONE_W) : MD;
      mr_mag = (signed_mode && MR[WIDTH-1]) ? (~MR + ONE_W) : MR;
   end

   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = init ? S_CHECK : S_IDLE;
         S_CHECK: begin
            if (b == '0)
               state_next = S_FIX;
            else if (b[0])
               state_next = S_ADD;
            else
               state_next = S_SHIFT;
         end
         S_ADD:   state_next = S_SHIFT;
         S_SHIFT: state_next = S_CHECK;
         S_FIX:   state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a         <= '0;
         b         <= '0;
         pp        <= '0;
         sign      <= 1'b0;
         resultado <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (init) begin
                  a    <= {{WIDTH{1'b0}}, md_mag};
                  b    <= mr_mag;
                  pp   <= '0;
                  sign <= signed_mode & (MD[WIDTH-1] ^ MR[WIDTH-1]);
                  busy <= 1'b1;
               end
            end
            S_ADD:   pp <= pp + a;
            S_SHIFT: begin
               a <= a << 1;
               b <= b >> 1;
            end
            S_FIX: begin
               resultado <= sign ? (~pp + ONE_2W) : pp;
               done      <= 1'b1;
               busy      <= 1'b0;
            end
            S_DONE:  done <= 1'b0;
            S_CHECK: ;
            default: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplicador_param.sv
// Bench for multiplicador_param at WIDTH 3, 4 and 8: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed products and completion latencies.
module tb_multiplicador_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_v [3];
   logic        sm_v   [3];
   logic [15:0] md_v   [3];
   logic [15:0] mr_v   [3];
   logic [5:0]  res0;
   logic [7:0]  res1;
   logic [15:0] res2;
   logic        busy_v [3];
   logic        done_v [3];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: per-instance phase, remaining edges and pending product.
   bit          m_idle [3];
   bit          m_busy [3];
   bit          m_done [3];
   int          m_rem  [3];
   logic [31:0] m_res  [3];
   logic [31:0] m_pend [3];

   always #5 clk = ~clk;

   multiplicador_param #(.WIDTH(3)) u0 (
      .clk(clk), .rst(rst), .init(init_v[0]), .signed_mode(sm_v[0]),
      .MD(md_v[0][2:0]), .MR(mr_v[0][2:0]),
      .resultado(res0), .busy(busy_v[0]), .done(done_v[0]));

   multiplicador_param #(.WIDTH(4)) u1 (
      .clk(clk), .rst(rst), .init(init_v[1]), .signed_mode(sm_v[1]),
      .MD(md_v[1][3:0]), .MR(mr_v[1][3:0]),
      .resultado(res1), .busy(busy_v[1]), .done(done_v[1]));

   multiplicador_param #(.WIDTH(8)) u2 (
      .clk(clk), .rst(rst), .init(init_v[2]), .signed_mode(sm_v[2]),
      .MD(md_v[2][7:0]), .MR(mr_v[2][7:0]),
      .resultado(res2), .busy(busy_v[2]), .done(done_v[2]));

   function automatic int wid(int i);
      case (i)
         0:       return 3;
         1:       return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] res_of(int i);
      case (i)
         0:       return {26'b0, res0};
         1:       return {24'b0, res1};
         default: return {16'b0, res2};
      endcase
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   function automatic void model_start(int i);
      longint w   = longint'(wid(i));
      longint mdv = longint'(md_v[i]) & ((longint'(1) << w) - 1);
      longint mrv = longint'(mr_v[i]) & ((longint'(1) << w) - 1);
      longint mag;
      longint prod;
      int n = 0;
      int p = 0;
      if (sm_v[i]) begin
         if (mdv >= (longint'(1) << (w - 1))) mdv = mdv - (longint'(1) << w);
         if (mrv >= (longint'(1) << (w - 1))) mrv = mrv - (longint'(1) << w);
      end
      prod = mdv * mrv;
      mag  = (mrv < 0) ? -mrv : mrv;
      for (int k = 0; k < 17; k++) begin
         if (mag[k]) begin
            n = k + 1;
            p++;
         end
      end
      m_pend[i] = 32'(prod & ((longint'(1) << (2 * w)) - 1));
      m_rem[i]  = 2 * n + p + 2;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 3; i++) begin
         m_idle[i] = 1'b1;
         m_busy[i] = 1'b0;
         m_done[i] = 1'b0;
         m_rem[i]  = 0;
         m_res[i]  = '0;
         m_pend[i] = '0;
      end
   endfunction

   always @(negedge rst) model_clear();

   always @(posedge clk) begin
      if (!rst) begin
         model_clear();
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_done[i]) begin
               m_done[i] = 1'b0;
               m_idle[i] = 1'b1;
            end else if (m_idle[i]) begin
               if (init_v[i]) begin
                  model_start(i);
                  m_idle[i] = 1'b0;
                  m_busy[i] = 1'b1;
               end
            end else begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_busy[i] = 1'b0;
                  m_done[i] = 1'b1;
                  m_res[i]  = m_pend[i];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_busy%0d", i), longint'(busy_v[i]), longint'(m_busy[i]));
            chk($sformatf("model_done%0d", i), longint'(done_v[i]), longint'(m_done[i]));
            chk($sformatf("model_res%0d", i), longint'(res_of(i)), longint'(m_res[i]));
         end
      end
   end

   // Launch one operation on instance i; optionally disturb init/operands while it is busy.
   task automatic run(int i, logic [15:0] md, logic [15:0] mr, logic sm,
                      logic [31:0] exp, int lat, bit disturb);
      int k = 0;
      @(negedge clk);
      md_v[i]   = md;
      mr_v[i]   = mr;
      sm_v[i]   = sm;
      init_v[i] = 1'b1;
      @(negedge clk);
      init_v[i] = 1'b0;
      while (!done_v[i] && k < 100) begin
         if (disturb && k == 3) begin
            init_v[i] = 1'b1;
            md_v[i]   = 16'd1;
            mr_v[i]   = 16'd1;
            sm_v[i]   = 1'b1;
         end
         if (disturb && k == 6) init_v[i] = 1'b0;
         @(negedge clk);
         k++;
      end
      chk($sformatf("lat%0d", i), longint'(k), longint'(lat));
      chk($sformatf("res%0d", i), longint'(res_of(i)), longint'(exp));
      @(negedge clk);
      chk($sformatf("done_pulse%0d", i), longint'(done_v[i]), 0);
      chk($sformatf("busy_after%0d", i), longint'(busy_v[i]), 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         init_v[i] = 1'b0;
         sm_v[i]   = 1'b0;
         md_v[i]   = '0;
         mr_v[i]   = '0;
      end
      #1 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_busy%0d", i), longint'(busy_v[i]), 0);
         chk($sformatf("rst_done%0d", i), longint'(done_v[i]), 0);
         chk($sformatf("rst_res%0d", i), longint'(res_of(i)), 0);
      end
      chk_en = 1'b1;
      #2 rst = 1'b1;

      run(0, 16'd7,    16'd5,    1'b0, 32'h23,   10, 1'b0);
      run(1, 16'hD,    16'd5,    1'b1, 32'hF1,   10, 1'b0);
      run(1, 16'h8,    16'h8,    1'b1, 32'h40,   11, 1'b0);
      run(1, 16'd9,    16'd0,    1'b0, 32'h0,     2, 1'b0);
      run(1, 16'hF,    16'hF,    1'b0, 32'hE1,   14, 1'b0);
      run(1, 16'h7,    16'hF,    1'b1, 32'hF9,    5, 1'b0);
      run(2, 16'hFF,   16'hFF,   1'b0, 32'hFE01, 26, 1'b1);

      // Reset while instance 0 sits in ADD: everything clears at once, no done pulse.
      @(negedge clk);
      md_v[0]   = 16'd2;
      mr_v[0]   = 16'd3;
      sm_v[0]   = 1'b0;
      init_v[0] = 1'b1;
      @(negedge clk);
      init_v[0] = 1'b0;
      @(negedge clk);
      chk("busy_before_rst", longint'(busy_v[0]), 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", longint'(busy_v[0]), 0);
      chk("midrst_done", longint'(done_v[0]), 0);
      chk("midrst_res", longint'(res_of(0)), 0);
      chk("midrst_res2", longint'(res_of(2)), 0);
      @(negedge clk);
      #2 rst = 1'b1;
      run(0, 16'd2, 16'd3, 1'b0, 32'h6, 8, 1'b0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
